uart_two_way_comm: RTL and testbench

//   Full-duplex 8N1 UART with independent transmit and receive engines sharing one clock.
//   It is the serial link between the host and the matrix-multiply datapath:
//   - TX serialises a parallel byte onto tx.
//   - RX deserialises the rx line into data_out.
//   No parity, no FIFO; one byte in flight per direction.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_engine.sv | 95 +++++++++
 rtl/uart_two_way_comm.sv | 100 ++++++++++
 tb/tb_uart_two_way_comm.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// +--------------------------------------------------------------------+
// | uart_pkg : shared FSM state encoding and frame constants for UART  |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int FRAME_BITS = 10;

endpackage

`default_nettype wire

// File: rtl/uart_rx_engine.sv
// +--------------------------------------------------------------------+
// | uart_rx_engine : 2-flop synchroniser, 8N1 receive FSM, sticky flag |
// | Revision       : 1.0                                               |
// +--------------------------------------------------------------------+
`default_nettype none

module uart_rx_engine
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_ready
);

  localparam int                 c_cnt_w    = $clog2(CLKS_PER_BIT);
  localparam logic [c_cnt_w-1:0] c_bit_end  = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [c_cnt_w-1:0] c_half_end = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]         c_last_bit = 3'(FRAME_BITS - 3);

  state_t               r_state;
  state_t               w_next;
  logic                 r_rx_meta;
  logic                 r_rx_s;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [2:0]           r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 w_bit_end;
  logic                 w_half_end;
  logic                 w_shift_en;
  logic                 w_start_ok;
  logic                 w_frame_ok;

  assign w_bit_end  = (r_cnt == c_bit_end);
  assign w_half_end = (r_cnt == c_half_end);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      o_data    <= '0;
      o_ready   <= 1'b0;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_s    <= r_rx_meta;
      r_state   <= w_next;
      if (w_next != r_state) begin
        r_cnt <= '0;
        r_idx <= '0;
      end else if (r_state != IDLE) begin
        if (w_bit_end) begin
          r_cnt <= '0;
          r_idx <= r_idx + 3'd1;
        end else begin
          r_cnt <= r_cnt + c_cnt_w'(1);
        end
      end
      if (w_shift_en) r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
      // A confirmed start bit retires the previous byte's ready flag
      if (w_start_ok) o_ready <= 1'b0;
      if (w_frame_ok) begin
        o_data  <= r_shift;
        o_ready <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (!r_rx_s) w_next = START;
      START:   if (w_half_end) w_next = r_rx_s ? IDLE : DATA;
      DATA:    if (w_bit_end && (r_idx == c_last_bit)) w_next = STOP;
      STOP:    if (w_bit_end) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_shift_en = (r_state == DATA)  && w_bit_end;
    w_start_ok = (r_state == START) && w_half_end && !r_rx_s;
    w_frame_ok = (r_state == STOP)  && w_bit_end && r_rx_s;
  end

endmodule

`default_nettype wire

// File: rtl/uart_two_way_comm.sv
// +--------------------------------------------------------------------+
// | uart_two_way_comm : full-duplex 8N1 UART, inline TX FSM + RX engine|
// | Revision          : 1.0                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module uart_two_way_comm
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 tx_start,
  input  logic                 rx,
  output logic                 tx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 tx_busy,
  output logic                 rx_ready
);

  localparam int                 c_cnt_w    = $clog2(CLKS_PER_BIT);
  localparam logic [c_cnt_w-1:0] c_bit_end  = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [2:0]         c_last_bit = 3'(FRAME_BITS - 3);

  state_t               r_tx_state;
  state_t               w_tx_next;
  logic [c_cnt_w-1:0]   r_tx_cnt;
  logic [2:0]           r_tx_idx;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic                 w_tx_bit_end;

  assign w_tx_bit_end = (r_tx_cnt == c_bit_end);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_state <= IDLE;
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_shift <= '0;
    end else begin
      r_tx_state <= w_tx_next;
      if (w_tx_next != r_tx_state) begin
        r_tx_cnt <= '0;
        r_tx_idx <= '0;
      end else if (r_tx_state != IDLE) begin
        if (w_tx_bit_end) begin
          r_tx_cnt <= '0;
          r_tx_idx <= r_tx_idx + 3'd1;
        end else begin
          r_tx_cnt <= r_tx_cnt + c_cnt_w'(1);
        end
      end
      // Byte is captured only on acceptance, so later data_in changes are invisible
      if ((r_tx_state == IDLE) && tx_start) begin
        r_tx_shift <= data_in;
      end else if ((r_tx_state == DATA) && w_tx_bit_end) begin
        r_tx_shift <= r_tx_shift >> 1;
      end
    end
  end

  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      IDLE:    if (tx_start) w_tx_next = START;
      START:   if (w_tx_bit_end) w_tx_next = DATA;
      DATA:    if (w_tx_bit_end && (r_tx_idx == c_last_bit)) w_tx_next = STOP;
      STOP:    if (w_tx_bit_end) w_tx_next = IDLE;
      default: w_tx_next = IDLE;
    endcase
  end

  always_comb begin
    tx      = 1'b1;
    tx_busy = 1'b1;
    case (r_tx_state)
      IDLE:    tx_busy = 1'b0;
      START:   tx      = 1'b0;
      DATA:    tx      = r_tx_shift[0];
      default: tx      = 1'b1;
    endcase
  end

  uart_rx_engine #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .DATA_BITS    (DATA_BITS)
  ) u_rx_engine (
    .clk     (clk),
    .rst     (reset),
    .i_rx    (rx),
    .o_data  (data_out),
    .o_ready (rx_ready)
  );

endmodule

`default_nettype wire

// File: tb/tb_uart_two_way_comm.sv
// +--------------------------------------------------------------------+
// | tb_uart_two_way_comm : directed vector bench for uart_two_way_comm |
// | Revision             : 1.0                                         |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_uart_two_way_comm;

  localparam int CPB = 4;

  typedef struct {
    logic [7:0] tx_byte;
    logic [9:0] tx_frame;   // bit k = expected tx level in slot k
    logic [7:0] rx_byte;
    logic       rx_stop;
    logic [7:0] exp_dout;
    logic       exp_rdy;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       tx_start = 1'b0;
  logic       r_rx = 1'b1;
  logic       r_loop = 1'b0;
  logic       w_rx;
  logic       tx;
  logic [7:0] data_out;
  logic       tx_busy;
  logic       rx_ready;

  int n_vec = 0;
  int n_err = 0;
  vec_t vecs [5];

  assign w_rx = r_loop ? tx : r_rx;

  always #5 clk = ~clk;

  uart_two_way_comm #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .tx_start (tx_start),
    .rx       (w_rx),
    .tx       (tx),
    .data_out (data_out),
    .tx_busy  (tx_busy),
    .rx_ready (rx_ready)
  );

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send_tx(input logic [7:0] b, input logic [9:0] frame, input int id);
    @(negedge clk);
    data_in  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    data_in  = ~b;
    check($sformatf("v%0d busy rise", id), tx_busy, 1'b1);
    for (int j = 1; j <= 10 * CPB; j++) begin
      @(negedge clk);
      tx_start = (j == 5 * CPB);
      if (j % CPB == CPB / 2) check($sformatf("v%0d tx slot%0d", id, j / CPB), tx, frame[j / CPB]);
      if (j == 10 * CPB - 1) check($sformatf("v%0d busy last", id), tx_busy, 1'b1);
      if (j == 10 * CPB) begin
        check($sformatf("v%0d busy fall", id), tx_busy, 1'b0);
        check($sformatf("v%0d tx idle", id), tx, 1'b1);
      end
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      r_rx = f[i];
      repeat (CPB - 1) @(negedge clk);
    end
    @(negedge clk);
    r_rx = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    fork
      send_tx(v.tx_byte, v.tx_frame, id);
      send_rx(v.rx_byte, v.rx_stop);
    join
    repeat (3) @(negedge clk);
    check($sformatf("v%0d data_out", id), data_out, v.exp_dout);
    check($sformatf("v%0d rx_ready", id), rx_ready, v.exp_rdy);
  endtask

  initial begin
    vecs[0] = '{8'h55, 10'b1_01010101_0, 8'h3C, 1'b1, 8'h3C, 1'b1};
    vecs[1] = '{8'hA3, 10'b1_10100011_0, 8'hA5, 1'b0, 8'h3C, 1'b0};
    vecs[2] = '{8'h00, 10'b1_00000000_0, 8'hC3, 1'b1, 8'hC3, 1'b1};
    vecs[3] = '{8'hFF, 10'b1_11111111_0, 8'h00, 1'b1, 8'h00, 1'b1};
    vecs[4] = '{8'h81, 10'b1_10000001_0, 8'h7E, 1'b1, 8'h7E, 1'b1};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("reset tx", tx, 1'b1);
      check("reset busy", tx_busy, 1'b0);
      check("reset ready", rx_ready, 1'b0);
      check("reset dout", data_out, 8'h00);
    end

    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i], i);
      if (i == 0) begin
        repeat (20) @(negedge clk);
        check("ready sticky", rx_ready, 1'b1);
      end
    end

    // Single-cycle low on rx must not start a frame
    @(negedge clk);
    r_rx = 1'b0;
    @(negedge clk);
    r_rx = 1'b1;
    repeat (12) @(negedge clk);
    check("glitch ready", rx_ready, 1'b1);
    check("glitch dout", data_out, 8'h7E);

    // tx looped to rx
    r_loop = 1'b1;
    send_tx(8'h96, 10'b1_10010110_0, 10);
    repeat (4) @(negedge clk);
    check("loop dout", data_out, 8'h96);
    check("loop ready", rx_ready, 1'b1);
    r_loop = 1'b0;

    // Reset while TX and RX are both mid-frame
    @(negedge clk);
    data_in  = 8'h5A;
    tx_start = 1'b1;
    r_rx     = 1'b0;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre-reset busy", tx_busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("midreset tx", tx, 1'b1);
    check("midreset busy", tx_busy, 1'b0);
    check("midreset ready", rx_ready, 1'b0);
    check("midreset dout", data_out, 8'h00);
    r_rx  = 1'b1;
    reset = 1'b0;
    repeat (4) @(negedge clk);
    run_vec(vecs[0], 11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
